// File: rtl/biquad_coeff_pkg.sv
// Shared definitions for the biquad coefficient loader: data width, FSM encoding
// and the index-width helper.
package biquad_coeff_pkg;

    localparam int COEFF_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_GAP    = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/biquad_coeff_regfile.sv
// Coefficient register file: one synchronous write port, one combinational
// index-read port. Out-of-range indices are ignored on write and read as zero.
module biquad_coeff_regfile
    import biquad_coeff_pkg::*;
#(
    parameter int NCOEFF = 2,
    parameter int AW     = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [COEFF_W-1:0] wr_dat,
    input  logic [AW-1:0]      rd_addr,
    output logic [COEFF_W-1:0] rd_dat
);

    logic [COEFF_W-1:0] regs [NCOEFF];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEFF; i++) regs[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < NCOEFF)) begin
            regs[wr_addr] <= wr_dat;
        end
    end

    always_comb begin
        rd_dat = '0;
        if (int'(rd_addr) < NCOEFF) rd_dat = regs[rd_addr];
    end

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Streams a coefficient set into one or more biquad8 blocks, highest index first,
// then issues a single update strobe after a fixed idle gap.
//
// state  | meaning
// IDLE   | waiting for a load; register file writable
// WRITE  | coeff_wr_o asserted, one coefficient read per cycle
// GAP    | last word on coeff_dat_o, counting down the update gap
// UPDATE | coeff_update_o and done_o pulse; start a queued load if any
module biquad8_coeff_loader
    import biquad_coeff_pkg::*;
#(
    parameter int NCOEFF     = 2,
    parameter int NCHAN      = 1,
    parameter int UPDATE_GAP = 2,
    localparam int AW = idx_w(NCOEFF),
    localparam int GW = idx_w(UPDATE_GAP + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_wr_i,
    input  logic [AW-1:0]      cfg_addr_i,
    input  logic [COEFF_W-1:0] cfg_dat_i,
    input  logic               load_i,
    input  logic [NCHAN-1:0]   load_mask_i,
    input  logic               err_clr_i,
    output logic [COEFF_W-1:0] coeff_dat_o,
    output logic [NCHAN-1:0]   coeff_wr_o,
    output logic [NCHAN-1:0]   coeff_update_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    state_t             state;
    logic [AW-1:0]      wr_cnt;
    logic [GW-1:0]      gap_cnt;
    logic [NCHAN-1:0]   mask_q;
    logic [NCHAN-1:0]   pend_mask;
    logic               pend_v;
    logic [COEFF_W-1:0] rd_dat;
    logic               load_ok;
    logic               reg_we;
    logic               start_en;
    logic [NCHAN-1:0]   start_mask;
    logic               err_new;

    assign load_ok = load_i && (load_mask_i != '0);
    // Writes are blocked while busy, so the register file itself is the snapshot
    // taken at the IDLE->WRITE edge, including a write in the same cycle as load_i.
    assign reg_we  = cfg_wr_i && (state == ST_IDLE);
    assign err_new = (cfg_wr_i && (state != ST_IDLE)) || (load_ok && pend_v);

    biquad_coeff_regfile #(
        .NCOEFF (NCOEFF),
        .AW     (AW)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (reg_we),
        .wr_addr (cfg_addr_i),
        .wr_dat  (cfg_dat_i),
        .rd_addr (wr_cnt),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        start_en   = 1'b0;
        start_mask = load_mask_i;
        if (state == ST_IDLE) begin
            start_en = load_ok;
        end else if (state == ST_UPDATE) begin
            if (pend_v) begin
                start_en   = 1'b1;
                start_mask = pend_mask;
            end else begin
                start_en = load_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wr_cnt         <= '0;
            gap_cnt        <= '0;
            mask_q         <= '0;
            pend_mask      <= '0;
            pend_v         <= 1'b0;
            coeff_dat_o    <= '0;
            coeff_wr_o     <= '0;
            coeff_update_o <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            if (err_new)        err_o <= 1'b1;
            else if (err_clr_i) err_o <= 1'b0;

            case (state)
                ST_WRITE: begin
                    coeff_dat_o <= rd_dat;
                    if (wr_cnt == '0) begin
                        state      <= ST_GAP;
                        coeff_wr_o <= '0;
                        gap_cnt    <= GW'(UPDATE_GAP);
                    end else begin
                        wr_cnt <= wr_cnt - AW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state          <= ST_UPDATE;
                        coeff_update_o <= mask_q;
                        done_o         <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                ST_UPDATE: begin
                    coeff_update_o <= '0;
                    done_o         <= 1'b0;
                    pend_v         <= 1'b0;
                    if (!start_en) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: ;
            endcase

            if ((state == ST_WRITE || state == ST_GAP) && load_ok && !pend_v) begin
                pend_v    <= 1'b1;
                pend_mask <= load_mask_i;
            end

            if (start_en) begin
                state      <= ST_WRITE;
                mask_q     <= start_mask;
                coeff_wr_o <= start_mask;
                wr_cnt     <= AW'(NCOEFF - 1);
                busy_o     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for the coefficient loader; expected output cycles are queued
// when a load is driven and compared by a negedge monitor.
module tb_biquad8_coeff_loader;

    localparam int NCOEFF = 2;
    localparam int NCHAN  = 2;
    localparam int GAP    = 1;
    localparam int SEQ_LEN = NCOEFF + 2 + GAP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_wr_i = 1'b0;
    logic [0:0]  cfg_addr_i = '0;
    logic [17:0] cfg_dat_i = '0;
    logic        load_i = 1'b0;
    logic [1:0]  load_mask_i = '0;
    logic        err_clr_i = 1'b0;
    logic [17:0] coeff_dat_o;
    logic [1:0]  coeff_wr_o;
    logic [1:0]  coeff_update_o;
    logic        busy_o, done_o, err_o;

    biquad8_coeff_loader #(
        .NCOEFF(NCOEFF), .NCHAN(NCHAN), .UPDATE_GAP(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
        .cfg_dat_i(cfg_dat_i), .load_i(load_i), .load_mask_i(load_mask_i),
        .err_clr_i(err_clr_i), .coeff_dat_o(coeff_dat_o), .coeff_wr_o(coeff_wr_o),
        .coeff_update_o(coeff_update_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  wr;
        logic [1:0]  upd;
        logic        done;
        logic        dchk;
        logic [17:0] dat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [17:0] m_reg [NCOEFF];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          idle_chk = 1'b0;
    bit          upd_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs for a load accepted at cycle t.
    task automatic push_seq(input int t, input logic [1:0] m);
        exp_t e;
        for (int c = t + 1; c <= t + SEQ_LEN; c++) begin
            e.cyc  = c;
            e.wr   = (c <= t + NCOEFF) ? m : 2'b00;
            e.upd  = (c == t + SEQ_LEN) ? m : 2'b00;
            e.done = (c == t + SEQ_LEN);
            e.dchk = (c >= t + 2);
            e.dat  = (c <= t + NCOEFF + 1) ? m_reg[NCOEFF - 1 - (c - t - 2)] : m_reg[0];
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !idle_chk && coeff_update_o != 2'b00) upd_seen = 1'b1;
        if (rst_n) begin
            if (sb.size() != 0 && sb[0].cyc < cyc) begin
                chk("sb_missed_cycle", 32'(sb[0].cyc), 32'(cyc));
                void'(sb.pop_front());
            end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                chk("coeff_wr", 32'(coeff_wr_o), 32'(mon_e.wr));
                chk("coeff_update", 32'(coeff_update_o), 32'(mon_e.upd));
                chk("done", 32'(done_o), 32'(mon_e.done));
                chk("busy", 32'(busy_o), 32'd1);
                if (mon_e.dchk) chk("coeff_dat", 32'(coeff_dat_o), 32'(mon_e.dat));
            end else if (sb.size() == 0 && idle_chk) begin
                chk("idle_busy", 32'(busy_o), 32'd0);
                chk("idle_wr", 32'(coeff_wr_o), 32'd0);
                chk("idle_update", 32'(coeff_update_o), 32'd0);
                chk("idle_done", 32'(done_o), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cfg_wr_i  = 1'b0;
        load_i    = 1'b0;
        err_clr_i = 1'b0;
    endtask

    task automatic cfg(input logic [0:0] a, input logic [17:0] d, input bit model);
        cfg_wr_i   = 1'b1;
        cfg_addr_i = a;
        cfg_dat_i  = d;
        if (model) m_reg[a] = d;
    endtask

    task automatic load(input logic [1:0] m, input int push_at);
        load_i      = 1'b1;
        load_mask_i = m;
        if (push_at >= 0) push_seq(push_at, m);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        int t;
        for (int i = 0; i < NCOEFF; i++) m_reg[i] = '0;

        // reset state
        step(); step(); step();
        chk("rst_wr", 32'(coeff_wr_o), 32'd0);
        chk("rst_update", 32'(coeff_update_o), 32'd0);
        chk("rst_dat", 32'(coeff_dat_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        idle_chk = 1'b1;
        step();

        // basic stream, highest index first
        cfg(1'b0, 18'h00123, 1'b1); step();
        cfg(1'b1, 18'h3FF00, 1'b1); step();
        load(2'b01, cyc); step();
        drain();

        // same-cycle register write is included
        cfg(1'b0, 18'h00AAA, 1'b1);
        load(2'b11, cyc); step();
        drain();
        chk("err_after_same_cycle_wr", 32'(err_o), 32'd0);

        // queued load starts the cycle after UPDATE, no error
        t = cyc;
        load(2'b01, t); step();
        load(2'b10, t + SEQ_LEN); step();
        drain();
        chk("err_after_pending", 32'(err_o), 32'd0);

        // third load while one is pending is dropped and flagged
        t = cyc;
        load(2'b10, t); step();
        load(2'b01, t + SEQ_LEN); step();
        load(2'b11, -1); step();
        chk("err_dropped_load", 32'(err_o), 32'd1);
        drain();
        err_clr_i = 1'b1; step();
        chk("err_clr_1", 32'(err_o), 32'd0);

        // register write while busy is ignored and sets err_o; error beats clear
        t = cyc;
        load(2'b11, t); step();
        step();
        cfg(1'b1, 18'h11111, 1'b0); step();
        chk("err_busy_wr", 32'(err_o), 32'd1);
        cfg(1'b0, 18'h22222, 1'b0);
        err_clr_i = 1'b1; step();
        chk("err_set_and_clr", 32'(err_o), 32'd1);
        drain();
        chk("err_sticky", 32'(err_o), 32'd1);
        err_clr_i = 1'b1; step();
        chk("err_clr_2", 32'(err_o), 32'd0);
        load(2'b01, cyc); step();
        drain();

        // zero mask is ignored
        load(2'b00, -1); step();
        chk("zero_mask_busy", 32'(busy_o), 32'd0);
        step(); step(); step();

        // reset mid-sequence
        idle_chk = 1'b0;
        load(2'b11, -1); step();
        step();
        rst_n = 1'b0; step();
        chk("abort_wr", 32'(coeff_wr_o), 32'd0);
        chk("abort_update", 32'(coeff_update_o), 32'd0);
        chk("abort_dat", 32'(coeff_dat_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NCOEFF; i++) m_reg[i] = '0;
        idle_chk = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("abort_no_update", 32'(upd_seen), 32'd0);
        load(2'b10, cyc); step();
        drain();

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
